pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 64, max WAIT-state cycles before memory-wait abort.
REQ-002 Parameter: CNT_W, 16, width of stall counter.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 src1, src2  in  4 each  ID source register numbers.
REQ-007 two_src  in  1  src2 is read by ID instruction.
REQ-008 exe_wb_en, exe_dest, exe_mem_r_en  in  1/4/1  EXE writeback enable, destination, load flag.
REQ-009 mem_wb_en, mem_dest  in  1/4  MEM writeback enable, destination.
REQ-010 branch_taken  in  1  EXE resolved taken branch.
REQ-011 mem_req  in  1  MEM stage holds a load/store (level, held while frozen).
REQ-012 sram_ready  in  1  memory completion, one-cycle pulse.
REQ-013 if_freeze  out  1  hold PC and IF/ID register.
REQ-014 if_flush  out  1  clear IF/ID register.
REQ-015 id_flush  out  1  insert bubble into ID/EXE register.
REQ-016 pipe_freeze  out  1  hold all pipeline registers.
REQ-017 mem_err  out  1  sticky memory-timeout flag.
REQ-018 stall_cnt  out  CNT_W  count of cycles with if_freeze=1.

Function
REQ-019 FSM states RUN, WAIT; control outputs combinational (Mealy) from state and inputs, zero latency.
REQ-020 RUN, mem_req=1, sram_ready=0: pipe_freeze=1, next WAIT; mem_req=1 with sram_ready=1: no freeze, stay RUN.
REQ-021 WAIT: pipe_freeze=1 while sram_ready=0; sram_ready=1 -> pipe_freeze=0 that cycle, next RUN.
REQ-022 WAIT cycle counter cleared on RUN->WAIT, +1 per WAIT cycle; reaching TIMEOUT without sram_ready -> mem_err set, pipe_freeze=0 that cycle, next RUN.
REQ-023 mem_err sticky until reset.
REQ-024 raw = id_valid & ((exe_wb_en & exe_dest==src1) | (exe_wb_en & two_src & exe_dest==src2) | (mem_wb_en & mem_dest==src1) | (mem_wb_en & two_src & mem_dest==src2)).
REQ-025 raw=1 (no branch, no pipe_freeze): if_freeze=1, id_flush=1, if_flush=0.
REQ-026 branch_taken=1 (no pipe_freeze): if_flush=1, id_flush=1, if_freeze=0; branch overrides raw.
REQ-027 pipe_freeze=1 forces if_freeze=1, if_flush=0, id_flush=0; branch and raw ignored that cycle.
REQ-028 stall_cnt +1 each cycle if_freeze=1; saturates at all-ones.
REQ-029 Outputs never assert if_flush and if_freeze together.

Reset
REQ-030 rst asserted: state RUN, wait counter 0, mem_err 0, stall_cnt 0 immediately, independent of clk.
REQ-031 Reset during WAIT aborts wait; first cycle after release is RUN.
REQ-032 Combinational outputs 0 when all inputs 0 in RUN.

Configuration
REQ-033 Macro HAZARD_FORWARDING_EN defined: raw only when exe_wb_en & exe_mem_r_en & EXE match (load-use); MEM-stage matches ignored.
REQ-034 HAZARD_FORWARDING_EN undefined: raw per REQ-024.

Verification
REQ-035 id_valid=1, src1=3, exe_wb_en=1, exe_dest=3 -> if_freeze=1, id_flush=1 same cycle (undefined macro); 0 with macro and exe_mem_r_en=0.
REQ-036 raw=1 and branch_taken=1 same cycle -> if_flush=1, id_flush=1, if_freeze=0.
REQ-037 mem_req=1, sram_ready after 4 cycles -> pipe_freeze=1 for 4 cycles, 0 on ready cycle, state RUN next.
REQ-038 mem_req=1, no sram_ready, TIMEOUT=8 -> mem_err=1 after 8 WAIT cycles, stays 1, pipe_freeze drops.
REQ-039 CNT_W=4, if_freeze held 20 cycles -> stall_cnt=15, holds.
REQ-040 rst pulse mid-WAIT -> pipe_freeze=0, stall_cnt=0, mem_err=0 without clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall controller for a five-stage in-order pipeline. It decides,
// every cycle, whether the front end must hold, flush or bubble, and whether
// the whole pipeline must freeze while a memory access is outstanding.
//
// Control outputs are Mealy: they follow the current state and inputs within
// the same cycle. Only mem_err and stall_cnt are registered.
//
// Parameters
//   TIMEOUT  maximum number of WAIT-state cycles before a memory access is
//            abandoned and mem_err is raised
//   CNT_W    width of the saturating stall counter
//
// Configuration macro
//   HAZARD_FORWARDING_EN  when defined, the datapath is assumed to forward
//                         ALU results, so only a load in EXE whose destination
//                         matches an ID source (load-use) stalls. MEM-stage
//                         matches are ignored. When undefined, any pending
//                         EXE or MEM writeback to an ID source stalls.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   id_valid          ID stage holds a real instruction
//   src1, src2        ID source register numbers
//   two_src           ID instruction reads src2
//   exe_wb_en         EXE instruction writes back
//   exe_dest          EXE destination register
//   exe_mem_r_en      EXE instruction is a load
//   mem_wb_en         MEM instruction writes back
//   mem_dest          MEM destination register
//   branch_taken      EXE resolved a taken branch
//   mem_req           MEM stage holds a load/store (held while frozen)
//   sram_ready        one-cycle completion pulse from memory
//   if_freeze         hold PC and IF/ID register
//   if_flush          clear IF/ID register
//   id_flush          insert a bubble into ID/EXE register
//   pipe_freeze       hold every pipeline register
//   mem_err           sticky memory-timeout flag
//   stall_cnt         saturating count of cycles with if_freeze high
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // The wait counter holds the number of WAIT cycles already completed, so it
  // only ever needs to reach TIMEOUT-1.
  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    StRun,
    StWait
  } state_e;

  state_e           state;
  logic [WaitW-1:0] wait_cnt;

  logic exe_hit;
  logic mem_hit;
  logic raw;
  logic timeout_hit;

  // -------------------------------------------------------------------------
  // Data hazard detection
  // -------------------------------------------------------------------------
  assign exe_hit = (exe_dest == src1) | (two_src & (exe_dest == src2));
  assign mem_hit = (mem_dest == src1) | (two_src & (mem_dest == src2));

`ifdef HAZARD_FORWARDING_EN
  // Forwarding covers everything except a load whose data is not yet back.
  assign raw = id_valid & exe_wb_en & exe_mem_r_en & exe_hit;

  logic unused_fwd;
  assign unused_fwd = ^{mem_wb_en, mem_hit};
`else
  assign raw = id_valid & ((exe_wb_en & exe_hit) | (mem_wb_en & mem_hit));

  logic unused_fwd;
  assign unused_fwd = exe_mem_r_en;
`endif

  // -------------------------------------------------------------------------
  // Memory wait control
  // -------------------------------------------------------------------------
  // This is the TIMEOUT-th WAIT cycle and memory still has not answered.
  assign timeout_hit = (state == StWait) & ~sram_ready & (wait_cnt == WaitLast);

  always_comb begin
    pipe_freeze = 1'b0;
    unique case (state)
      StRun:   pipe_freeze = mem_req & ~sram_ready;
      StWait:  pipe_freeze = ~sram_ready & ~timeout_hit;
      default: pipe_freeze = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Front-end control, in priority order: freeze, branch, data hazard.
  // A frozen pipeline must not lose the fetched instruction, so branch and
  // hazard actions wait until the freeze lifts.
  // -------------------------------------------------------------------------
  always_comb begin
    if_freeze = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    if (pipe_freeze) begin
      if_freeze = 1'b1;
    end else if (branch_taken) begin
      // The stalled instruction is on the wrong path anyway, so the branch wins.
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (raw) begin
      if_freeze = 1'b1;
      id_flush  = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State, wait counter, sticky error and stall counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StRun;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (if_freeze && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      unique case (state)
        StRun: begin
          if (mem_req && !sram_ready) begin
            state    <= StWait;
            wait_cnt <= '0;
          end
        end
        StWait: begin
          if (sram_ready) begin
            state <= StRun;
          end else if (timeout_hit) begin
            // Abandon the access; the error stays set until reset.
            mem_err <= 1'b1;
            state   <= StRun;
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end
        default: state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT=8, CNT_W=4).
// A behavioural model tracks "is a memory access outstanding, and for how many
// wait cycles", the sticky error and the stall total; a negedge process checks
// every output against it each cycle. Directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int unsigned Timeout  = 8;
  localparam int unsigned CntW     = 4;
  localparam int          StallMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [3:0]      src1, src2;
  logic            two_src;
  logic            exe_wb_en;
  logic [3:0]      exe_dest;
  logic            exe_mem_r_en;
  logic            mem_wb_en;
  logic [3:0]      mem_dest;
  logic            branch_taken;
  logic            mem_req;
  logic            sram_ready;
  logic            if_freeze, if_flush, id_flush, pipe_freeze, mem_err;
  logic [CntW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_hazard_ctrl #(
    .TIMEOUT(Timeout),
    .CNT_W  (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .src1        (src1),
    .src2        (src2),
    .two_src     (two_src),
    .exe_wb_en   (exe_wb_en),
    .exe_dest    (exe_dest),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en   (mem_wb_en),
    .mem_dest    (mem_dest),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .sram_ready  (sram_ready),
    .if_freeze   (if_freeze),
    .if_flush    (if_flush),
    .id_flush    (id_flush),
    .pipe_freeze (pipe_freeze),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_waiting = 1'b0;  // memory access outstanding (WAIT)
  int m_waited  = 0;     // WAIT cycles already spent
  bit m_err     = 1'b0;
  int m_stall   = 0;

  function automatic bit model_raw();
`ifdef HAZARD_FORWARDING_EN
    return id_valid && exe_wb_en && exe_mem_r_en &&
           (exe_dest == src1 || (two_src && exe_dest == src2));
`else
    return id_valid && ((exe_wb_en && exe_dest == src1) ||
                        (exe_wb_en && two_src && exe_dest == src2) ||
                        (mem_wb_en && mem_dest == src1) ||
                        (mem_wb_en && two_src && mem_dest == src2));
`endif
  endfunction

  // Returns {pipe_freeze, if_freeze, if_flush, id_flush}.
  function automatic logic [3:0] model_ctrl();
    bit pf;
    if (m_waiting) pf = !sram_ready && (m_waited + 1 < Timeout);
    else           pf = mem_req && !sram_ready;
    if (pf)                return 4'b1100;
    else if (branch_taken) return 4'b0011;
    else if (model_raw())  return 4'b0101;
    else                   return 4'b0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_waiting = 1'b0;
      m_waited  = 0;
      m_err     = 1'b0;
      m_stall   = 0;
    end else begin
      logic [3:0] c;
      c = model_ctrl();
      if (c[2] && m_stall < StallMax) m_stall = m_stall + 1;
      if (m_waiting) begin
        if (sram_ready) begin
          m_waiting = 1'b0;
        end else if (m_waited + 1 == Timeout) begin
          m_waiting = 1'b0;
          m_err     = 1'b1;
        end else begin
          m_waited = m_waited + 1;
        end
      end else if (mem_req && !sram_ready) begin
        m_waiting = 1'b1;
        m_waited  = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("ctrl{pf,iff,ifl,idf}", {28'd0, pipe_freeze, if_freeze, if_flush, id_flush},
        {28'd0, model_ctrl()});
    chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; src1 = 0; src2 = 0; two_src = 0;
    exe_wb_en = 0; exe_dest = 0; exe_mem_r_en = 0;
    mem_wb_en = 0; mem_dest = 0; branch_taken = 0;
    mem_req = 0; sram_ready = 0;
  endtask

  task automatic set_raw(input bit load);
    id_valid = 1; src1 = 4'd3; exe_wb_en = 1; exe_dest = 4'd3; exe_mem_r_en = load;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    step();
    #1;
    chk("reset outputs", {27'd0, pipe_freeze, if_freeze, if_flush, id_flush, mem_err}, 0);
    chk("reset stall_cnt", {28'd0, stall_cnt}, 0);
    step();
    rst = 1'b0;
    #1;
    chk("idle outputs zero", {27'd0, pipe_freeze, if_freeze, if_flush, id_flush, mem_err}, 0);

    // EXE hazard on src1, not a load
    step();
    set_raw(1'b0);
    #1;
`ifdef HAZARD_FORWARDING_EN
    chk("alu hazard if_freeze", {31'd0, if_freeze}, 0);
    chk("alu hazard id_flush", {31'd0, id_flush}, 0);
`else
    chk("alu hazard if_freeze", {31'd0, if_freeze}, 1);
    chk("alu hazard id_flush", {31'd0, id_flush}, 1);
`endif

    // Load-use hazard with a taken branch: branch wins
    step();
    set_raw(1'b1);
    branch_taken = 1;
    #1;
    chk("branch over raw", {29'd0, if_flush, id_flush, if_freeze}, 3'b110);

    // Memory access answered on the fifth cycle
    step();
    clear_inputs();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mem wait freeze", {31'd0, pipe_freeze}, 1);
      step();
    end
    sram_ready = 1;
    #1;
    chk("ready cycle unfreeze", {31'd0, pipe_freeze}, 0);
    step();
    mem_req = 0; sram_ready = 0;
    #1;
    chk("back in run", {31'd0, pipe_freeze}, 0);

    // Memory timeout
    step();
    mem_req = 1;
    for (int i = 0; i < Timeout; i++) begin
      #1;
      chk("timeout freeze", {31'd0, pipe_freeze}, 1);
      step();
    end
    #1;
    chk("timeout cycle unfreeze", {31'd0, pipe_freeze}, 0);
    chk("err not yet", {31'd0, mem_err}, 0);
    step();
    mem_req = 0;
    #1;
    chk("err set", {31'd0, mem_err}, 1);
    repeat (3) step();
    chk("err sticky", {31'd0, mem_err}, 1);

    // Asynchronous reset in the middle of a wait
    mem_req = 1;
    repeat (3) step();
    #1;
    rst = 1'b1;
    mem_req = 0;
    #1;
    chk("async rst pipe_freeze", {31'd0, pipe_freeze}, 0);
    chk("async rst mem_err", {31'd0, mem_err}, 0);
    chk("async rst stall_cnt", {28'd0, stall_cnt}, 0);
    step();
    rst = 1'b0;
    #1;
    chk("run after reset", {31'd0, pipe_freeze}, 0);

    // Stall counter saturation
    set_raw(1'b1);
    repeat (10) step();
    chk("stall_cnt 10", {28'd0, stall_cnt}, 10);
    repeat (10) step();
    chk("stall_cnt saturated", {28'd0, stall_cnt}, StallMax);
    repeat (3) step();
    chk("stall_cnt holds", {28'd0, stall_cnt}, StallMax);

    // Randomised phase
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      id_valid     = ($urandom_range(0, 3) != 0);
      src1         = 4'($urandom_range(0, 3));
      src2         = 4'($urandom_range(0, 3));
      two_src      = 1'($urandom);
      exe_wb_en    = 1'($urandom);
      exe_dest     = 4'($urandom_range(0, 3));
      exe_mem_r_en = 1'($urandom);
      mem_wb_en    = 1'($urandom);
      mem_dest     = 4'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      sram_ready   = ($urandom_range(0, 4) == 0);
    end

    rst = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
